prio_drain: RTL and testbench

- Sequential drain stage for request vectors.
- Accepts one DW-bit vector on a valid/ready handshake and holds it in a pending register.
- Emits the set bits one at a time, highest index first, as one-hot grants with a binary index, on a valid/ready output stream.
- Used where a combinational highest-priority picker must be applied repeatedly until every request in a snapshot has been serviced.

---
 rtl/prio_drain.sv | 103 ++++++++++
 tb/tb_prio_drain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_drain.sv
// prio_drain: takes a request vector on a valid/ready handshake and hands its set bits back
// one per grant, highest index first. Optional macro PRIO_DRAIN_OVERLAP_EN lets the next vector load on the final grant.
module prio_drain #(
   parameter  int DW = 64,
   localparam int IW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [DW-1:0] pending_q, pending_d;
   logic [DW-1:0] out_q, out_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          last_q, last_d;
   logic          fire;
   logic          accept;

   // Index of the highest set bit; zero for an empty vector.
   function automatic logic [IW-1:0] msb_idx(input logic [DW-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) begin
         if (v[i]) r = IW'(i);
      end
      return r;
   endfunction

   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q == DRAIN);
   assign out       = out_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign fire      = out_valid && out_ready;

`ifdef PRIO_DRAIN_OVERLAP_EN
   // The retiring final grant frees the pending register in the same cycle.
   assign in_ready = (state_q == IDLE) || (fire && last_q);
`else
   assign in_ready = (state_q == IDLE);
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      if (fire) begin
         pending_d = pending_q & ~out_q;
         if (last_q) state_d = IDLE;
      end
      // A zero vector is consumed but never enters DRAIN.
      if (accept && (in != '0)) begin
         pending_d = in;
         state_d   = DRAIN;
      end
   end

   // Grant outputs are decoded from next-state values so they register alongside pending.
   always_comb begin
      idx_d  = '0;
      out_d  = '0;
      last_d = 1'b0;
      if (state_d == DRAIN) begin
         idx_d  = msb_idx(pending_d);
         out_d  = ONE << idx_d;
         last_d = ((pending_d & (pending_d - ONE)) == '0);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         out_q     <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
      end
   end

endmodule

// File: tb/tb_prio_drain.sv
// Directed bench for prio_drain: a DW=64 instance for most scenarios and a DW=2 instance for the narrow case.
module tb_prio_drain;

   logic        clk;
   logic        nreset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_vec;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out;
   logic [5:0]  out_idx;
   logic        out_last;
   logic        busy;

   logic        in_valid2;
   logic        in_ready2;
   logic [1:0]  in_vec2;
   logic        out_valid2;
   logic        out_ready2;
   logic [1:0]  out2;
   logic        out_idx2;
   logic        out_last2;
   logic        busy2;

   int checks;
   int errors;

   localparam logic [63:0] ONE64 = 64'd1;

   prio_drain #(.DW(64)) dut (
      .clk(clk), .nreset(nreset),
      .in_valid(in_valid), .in_ready(in_ready), .in(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   prio_drain #(.DW(2)) dut2 (
      .clk(clk), .nreset(nreset),
      .in_valid(in_valid2), .in_ready(in_ready2), .in(in_vec2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out(out2),
      .out_idx(out_idx2), .out_last(out_last2), .busy(busy2)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
      in_valid2 = 1'b0; in_vec2 = '0; out_ready2 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out !== 64'd0 || out_idx !== 6'd0 || out_last !== 1'b0 ||
          busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: valid=%b out=%h idx=%0d last=%b busy=%b in_ready=%b, required 0 0 0 0 0 1",
                  out_valid, out, out_idx, out_last, busy, in_ready);
      end
      checks++;
      if (out_valid2 !== 1'b0 || out2 !== 2'b00 || in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dw2: valid=%b out=%b in_ready=%b busy=%b, required 0 00 1 0",
                  out_valid2, out2, in_ready2, busy2);
      end
      tick();
      nreset = 1'b1;
   endtask

   task automatic test_basic();
      int exp_i[3];
      exp_i = '{15, 2, 0};
      in_valid = 1'b1; in_vec = 64'h8005; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_accept: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0; in_vec = '0;
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 6'(exp_i[g]) || out !== (ONE64 << exp_i[g]) ||
             out_last !== (g == 2) || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant%0d: valid=%b idx=%0d out=%h last=%b busy=%b in_ready=%b, required 1 %0d %h %b 1 0",
                     g, out_valid, out_idx, out, out_last, busy, in_ready, exp_i[g], ONE64 << exp_i[g], g == 2);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle: valid=%b out=%h busy=%b in_ready=%b, required 0 0 0 1",
                  out_valid, out, busy, in_ready);
      end
      tick();
   endtask

   task automatic test_zero();
      in_valid = 1'b1; in_vec = '0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 64'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_vec c%0d: valid=%b busy=%b out=%h in_ready=%b, required 0 0 0 1",
                     c, out_valid, busy, out, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_all_ones();
      int e;
      int k;
      in_valid = 1'b1; in_vec = '1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = '0;
      e = 63;
      k = 0;
      while (e >= 0 && k < 300) begin
         out_ready = (k % 2 == 0);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 6'(e) || out !== (ONE64 << e) || out_last !== (e == 0)) begin
            errors++;
            $display("FAIL all_ones k%0d: valid=%b idx=%0d out=%h last=%b, required 1 %0d %h %b",
                     k, out_valid, out_idx, out, out_last, e, ONE64 << e, e == 0);
         end
         if (out_ready) e--;
         k++;
         tick();
      end
      checks++;
      if (e >= 0) begin
         errors++;
         $display("FAIL all_ones_timeout: remaining=%0d required -1", e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL all_ones_end: valid=%b busy=%b, required 0 0", out_valid, busy);
      end
      tick();
   endtask

   task automatic test_single_bit();
      in_valid = 1'b1; in_vec = ONE64 << 63; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = '0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'd63 || out_last !== 1'b1 || out !== (ONE64 << 63)) begin
         errors++;
         $display("FAIL single_bit: valid=%b idx=%0d last=%b out=%h, required 1 63 1 %h",
                  out_valid, out_idx, out_last, out, ONE64 << 63);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_bit_end: valid=%b required 0", out_valid);
      end
      // Narrow instance, both bits set.
      in_valid2 = 1'b1; in_vec2 = 2'b11; out_ready2 = 1'b1;
      tick();
      in_valid2 = 1'b0; in_vec2 = 2'b00;
      @(negedge clk);
      checks++;
      if (out_valid2 !== 1'b1 || out_idx2 !== 1'b1 || out2 !== 2'b10 || out_last2 !== 1'b0) begin
         errors++;
         $display("FAIL dw2_first: valid=%b idx=%b out=%b last=%b, required 1 1 10 0",
                  out_valid2, out_idx2, out2, out_last2);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid2 !== 1'b1 || out_idx2 !== 1'b0 || out2 !== 2'b01 || out_last2 !== 1'b1) begin
         errors++;
         $display("FAIL dw2_second: valid=%b idx=%b out=%b last=%b, required 1 0 01 1",
                  out_valid2, out_idx2, out2, out_last2);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL dw2_end: valid=%b busy=%b, required 0 0", out_valid2, busy2);
      end
      tick();
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_vec = 64'hF0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = '0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'd7) begin
         errors++;
         $display("FAIL areset_first: valid=%b idx=%0d, required 1 7", out_valid, out_idx);
      end
      tick();
      #2;
      nreset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_drop: valid=%b out=%h busy=%b in_ready=%b, required 0 0 0 1",
                  out_valid, out, busy, in_ready);
      end
      tick();
      tick();
      nreset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_after c%0d: valid=%b busy=%b, required 0 0", c, out_valid, busy);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int gcyc[8];
      int gidx[8];
      int exp_cyc[4];
      int exp_idx[4];
      int nrec;
      int sent;
      logic acc;
`ifdef PRIO_DRAIN_OVERLAP_EN
      exp_cyc = '{1, 2, 3, 4};
`else
      exp_cyc = '{1, 2, 4, 5};
`endif
      exp_idx = '{1, 0, 2, 0};
      nrec = 0;
      sent = 0;
      in_valid = 1'b1; in_vec = 64'h3; out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (out_valid && out_ready && nrec < 8) begin
            gcyc[nrec] = cyc;
            gidx[nrec] = int'(out_idx);
            nrec++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            sent++;
            if (sent == 1) begin
               in_vec = 64'h5;
            end else begin
               in_valid = 1'b0;
               in_vec = '0;
            end
         end
      end
      checks++;
      if (nrec != 4) begin
         errors++;
         $display("FAIL b2b_count: grants=%0d required 4", nrec);
      end
      for (int g = 0; g < 4; g++) begin
         if (g < nrec) begin
            checks++;
            if (gcyc[g] != exp_cyc[g] || gidx[g] != exp_idx[g]) begin
               errors++;
               $display("FAIL b2b_grant%0d: cycle=%0d idx=%0d, required cycle=%0d idx=%0d",
                        g, gcyc[g], gidx[g], exp_cyc[g], exp_idx[g]);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_zero();
      test_all_ones();
      test_single_bit();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
